// File: rtl/fsk_pkg.sv
// Shared types and constants for the FSK frame transmitter.
package fsk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SYNC,
        ST_LEN,
        ST_PAYLOAD,
        ST_CRC
    } fsk_state_t;

    localparam logic [7:0] PREAMBLE_BYTE = 8'hAA;
    localparam logic [7:0] CRC8_POLY     = 8'h07;

endpackage

// File: rtl/fsk_crc8.sv
// Byte-wide CRC-8 (MSB first, init 0, no reflection, no final XOR) with its register.
module fsk_crc8
    import fsk_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       upd,
    input  logic [7:0] din,
    output logic [7:0] crc
);

    logic [7:0] crc_nxt;

    // Eight serial polynomial steps unrolled into one combinational byte update
    always_comb begin
        crc_nxt = crc ^ din;
        for (int i = 0; i < 8; i++) begin
            crc_nxt = crc_nxt[7] ? ((crc_nxt << 1) ^ CRC8_POLY) : (crc_nxt << 1);
        end
    end

    // CRC register: cleared at frame start, advanced once per covered byte
    always_ff @(posedge clk) begin
        if (rst || clr) crc <= 8'h00;
        else if (upd)   crc <= crc_nxt;
    end

endmodule

// File: rtl/fsk_frame_tx.sv
// FSK frame transmitter: preamble, sync, length, payload (and optional CRC-8)
// serialised MSB first as NRZ bits of CLK_DIV cycles each.
// Optional feature macro: FSK_FRAME_CRC_EN appends a CRC-8 over len + payload.
module fsk_frame_tx
    import fsk_pkg::*;
#(
    parameter int unsigned CLK_DIV        = 5000,
    parameter int unsigned PREAMBLE_BYTES = 2,
    parameter logic [7:0]  SYNC_WORD      = 8'hD3
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       start,
    input  logic [7:0] len,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_bit,
    output logic       bit_strobe,
    output logic       busy,
    output logic       done,
    output logic       underrun
);

    localparam logic [15:0] BIT_LAST = 16'(CLK_DIV - 1);
    localparam logic [3:0]  PRE_LAST = 4'(PREAMBLE_BYTES - 1);

    fsk_state_t state;
    logic [15:0] bit_cnt;
    logic [2:0]  bit_idx;
    logic [3:0]  pre_cnt;
    logic [7:0]  send_left;   // payload bytes not yet moved into the shifter
    logic [7:0]  fetch_left;  // payload bytes not yet pulled into the holding register
    logic [7:0]  len_q;
    logic [7:0]  shreg;
    logic [7:0]  hold;
    logic        hold_vld;

    logic       bit_end, byte_end, accept, take;
    logic       nb_end, nb_abort, nb_pay;
    logic [7:0] nb_byte;
    fsk_state_t nb_state;

`ifdef FSK_FRAME_CRC_EN
    logic [7:0] crc;
    logic       crc_upd;

    // Only bytes actually loaded for transmission (len, payload) feed the CRC
    assign crc_upd = byte_end && !nb_abort && !nb_end && ((state == ST_SYNC) || nb_pay);

    fsk_crc8 u_crc (
        .clk (sys_clk),
        .rst (sys_rst),
        .clr (accept),
        .upd (crc_upd),
        .din (nb_byte),
        .crc (crc)
    );
`endif

    assign busy     = (state != ST_IDLE);
    assign tx_ready = ((state == ST_LEN) || (state == ST_PAYLOAD)) && !hold_vld && (fetch_left != 8'd0);
    assign take     = tx_valid && tx_ready;
    // done high means the frame ended this cycle; a start coinciding with it is dropped
    assign accept   = start && (state == ST_IDLE) && !done;
    assign bit_end  = (bit_cnt == BIT_LAST);
    assign byte_end = bit_end && (bit_idx == 3'd7);

    // Decide what happens at the next byte boundary: next byte/state, frame end or abort
    always_comb begin
        nb_byte  = PREAMBLE_BYTE;
        nb_state = state;
        nb_end   = 1'b0;
        nb_abort = 1'b0;
        nb_pay   = 1'b0;
        case (state)
            ST_PREAMBLE: begin
                if (pre_cnt == PRE_LAST) begin
                    nb_state = ST_SYNC;
                    nb_byte  = SYNC_WORD;
                end
            end
            ST_SYNC: begin
                nb_state = ST_LEN;
                nb_byte  = len_q;
            end
            ST_LEN, ST_PAYLOAD: begin
                if (send_left == 8'd0) begin
`ifdef FSK_FRAME_CRC_EN
                    nb_state = ST_CRC;
                    nb_byte  = crc;
`else
                    nb_end   = 1'b1;
`endif
                end else if (hold_vld) begin
                    nb_state = ST_PAYLOAD;
                    nb_byte  = hold;
                    nb_pay   = 1'b1;
                end else begin
                    nb_abort = 1'b1;
                end
            end
`ifdef FSK_FRAME_CRC_EN
            ST_CRC: nb_end = 1'b1;
`endif
            default: ;
        endcase
    end

    // Main FSM: bit timing, shifter, holding register and registered strobes
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= ST_IDLE;
            bit_cnt    <= 16'd0;
            bit_idx    <= 3'd0;
            pre_cnt    <= 4'd0;
            send_left  <= 8'd0;
            fetch_left <= 8'd0;
            len_q      <= 8'd0;
            shreg      <= 8'd0;
            hold       <= 8'd0;
            hold_vld   <= 1'b0;
            tx_bit     <= 1'b1;
            bit_strobe <= 1'b0;
            done       <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            bit_strobe <= 1'b0;
            done       <= 1'b0;
            underrun   <= 1'b0;
            if (take) begin
                hold       <= tx_data;
                hold_vld   <= 1'b1;
                fetch_left <= fetch_left - 8'd1;
            end
            if (state == ST_IDLE) begin
                if (accept) begin
                    state      <= ST_PREAMBLE;
                    len_q      <= len;
                    send_left  <= len;
                    fetch_left <= len;
                    pre_cnt    <= 4'd0;
                    bit_cnt    <= 16'd0;
                    bit_idx    <= 3'd0;
                    hold_vld   <= 1'b0;
                    shreg      <= PREAMBLE_BYTE;
                    tx_bit     <= PREAMBLE_BYTE[7];
                    bit_strobe <= 1'b1;
                end
            end else if (!bit_end) begin
                bit_cnt <= bit_cnt + 16'd1;
            end else begin
                bit_cnt <= 16'd0;
                if (!byte_end) begin
                    bit_idx    <= bit_idx + 3'd1;
                    shreg      <= shreg << 1;
                    tx_bit     <= shreg[6];
                    bit_strobe <= 1'b1;
                end else if (nb_abort) begin
                    state    <= ST_IDLE;
                    tx_bit   <= 1'b1;
                    underrun <= 1'b1;
                end else if (nb_end) begin
                    state  <= ST_IDLE;
                    tx_bit <= 1'b1;
                    done   <= 1'b1;
                end else begin
                    state      <= nb_state;
                    bit_idx    <= 3'd0;
                    shreg      <= nb_byte;
                    tx_bit     <= nb_byte[7];
                    bit_strobe <= 1'b1;
                    if (state == ST_PREAMBLE) pre_cnt <= pre_cnt + 4'd1;
                    if (nb_pay) begin
                        hold_vld  <= 1'b0;
                        send_left <= send_left - 8'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fsk_frame_tx.sv
// Table-driven bench for fsk_frame_tx (CLK_DIV=4, 2 preamble bytes, sync 0xD3).
// Define FSK_FRAME_CRC_EN for both bench and RTL to exercise the CRC build.
module tb_fsk_frame_tx;

    localparam int CLK_DIV = 4;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] len = 8'd0;
    logic [7:0] tx_data = 8'd0;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_bit, bit_strobe, busy, done, underrun;

    int checks = 0;
    int errors = 0;

    always #5 sys_clk = ~sys_clk;

    fsk_frame_tx #(.CLK_DIV(CLK_DIV), .PREAMBLE_BYTES(2), .SYNC_WORD(8'hD3)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .len(len),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_bit(tx_bit),
        .bit_strobe(bit_strobe), .busy(busy), .done(done), .underrun(underrun)
    );

    typedef struct {
        logic [7:0] len;
        logic [7:0] pay[4];
        int         hold_idx;   // payload index whose tx_valid is withheld, -1 none
        int         nbytes;
        logic [7:0] exp[8];
        bit         exp_done;
        int         exp_cyc;    // cycles from first strobe to done/underrun
        int         exp_fetch;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] crc8_ref(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int k = 0; k < 8; k++) r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
        return r;
    endfunction

    task automatic run_frame(input vec_t v, input string tag);
        int idx = 0, nbits = 0, fetches = 0, rdy = 0, glitch = 0, cyc = -1;
        logic [7:0] acc = 8'd0;
        logic [7:0] got[$];
        bit fin = 0, saw_done = 0, saw_under = 0;
        logic prev_bit = 1'b1, term_bit = 1'b0, term_busy = 1'b1;
        @(negedge sys_clk);
        len = v.len; start = 1'b1; tx_valid = 1'b0;
        @(negedge sys_clk);
        start = 1'b0;
        chk({tag, " first strobe"}, bit_strobe, 1'b1);
        chk({tag, " busy after start"}, busy, 1'b1);
        for (int c = 0; c < 600 && !fin; c++) begin
            if (c > 0) @(negedge sys_clk);
            if (done || underrun) begin
                fin = 1; cyc = c; saw_done = done; saw_under = underrun;
                term_bit = tx_bit; term_busy = busy;
            end else begin
                if (tx_bit !== prev_bit && !bit_strobe) glitch++;
                if (bit_strobe) begin
                    acc = {acc[6:0], tx_bit};
                    nbits++;
                    if (nbits % 8 == 0) got.push_back(acc);
                end
            end
            prev_bit = tx_bit;
            if (tx_ready) rdy++;
            tx_data  = (idx < 4) ? v.pay[idx] : 8'h00;
            tx_valid = (idx < int'(v.len)) && (idx != v.hold_idx);
            if (tx_valid && tx_ready) begin idx++; fetches++; end
        end
        tx_valid = 1'b0;
        if (!fin) chk({tag, " timeout"}, 0, 1);
        chk({tag, " done"}, saw_done, v.exp_done);
        chk({tag, " underrun"}, saw_under, !v.exp_done);
        chk({tag, " cycles"}, cyc, v.exp_cyc);
        chk({tag, " end tx_bit"}, term_bit, 1'b1);
        chk({tag, " end busy"}, term_busy, 1'b0);
        chk({tag, " glitches"}, glitch, 0);
        chk({tag, " fetches"}, fetches, v.exp_fetch);
        if (v.len == 8'd0) chk({tag, " tx_ready seen"}, rdy, 0);
        chk({tag, " byte count"}, got.size(), v.nbytes);
        for (int b = 0; b < v.nbytes && b < got.size(); b++)
            chk($sformatf("%s byte%0d", tag, b), got[b], v.exp[b]);
    endtask

    initial begin
        logic [31:0] pat;
        int strobes;
        bit bad_pulse;

        // len=2, 0x12 0x34
        vecs[0].len = 8'd2; vecs[0].pay = '{8'h12, 8'h34, 8'h00, 8'h00}; vecs[0].hold_idx = -1;
        vecs[0].exp = '{8'hAA, 8'hAA, 8'hD3, 8'h02, 8'h12, 8'h34, 8'h00, 8'h00};
        vecs[0].nbytes = 6; vecs[0].exp_done = 1; vecs[0].exp_cyc = 192; vecs[0].exp_fetch = 2;
        // len=0
        vecs[1].len = 8'd0; vecs[1].pay = '{8'h55, 8'h00, 8'h00, 8'h00}; vecs[1].hold_idx = -1;
        vecs[1].exp = '{8'hAA, 8'hAA, 8'hD3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[1].nbytes = 4; vecs[1].exp_done = 1; vecs[1].exp_cyc = 128; vecs[1].exp_fetch = 0;
        // len=3, second byte withheld -> underrun after byte 0x12
        vecs[2].len = 8'd3; vecs[2].pay = '{8'h12, 8'h34, 8'h56, 8'h00}; vecs[2].hold_idx = 1;
        vecs[2].exp = '{8'hAA, 8'hAA, 8'hD3, 8'h03, 8'h12, 8'h00, 8'h00, 8'h00};
        vecs[2].nbytes = 5; vecs[2].exp_done = 0; vecs[2].exp_cyc = 160; vecs[2].exp_fetch = 1;
        // len=1, 0xC5
        vecs[3].len = 8'd1; vecs[3].pay = '{8'hC5, 8'h00, 8'h00, 8'h00}; vecs[3].hold_idx = -1;
        vecs[3].exp = '{8'hAA, 8'hAA, 8'hD3, 8'h01, 8'hC5, 8'h00, 8'h00, 8'h00};
        vecs[3].nbytes = 5; vecs[3].exp_done = 1; vecs[3].exp_cyc = 160; vecs[3].exp_fetch = 1;
`ifdef FSK_FRAME_CRC_EN
        vecs[0].exp[6] = crc8_ref(crc8_ref(crc8_ref(8'h00, 8'h02), 8'h12), 8'h34);
        vecs[0].nbytes = 7; vecs[0].exp_cyc = 224;
        vecs[1].exp[4] = crc8_ref(8'h00, 8'h00);
        vecs[1].nbytes = 5; vecs[1].exp_cyc = 160;
        vecs[3].exp[5] = crc8_ref(crc8_ref(8'h00, 8'h01), 8'hC5);
        vecs[3].nbytes = 6; vecs[3].exp_cyc = 192;
`endif

        // Reset state
        repeat (3) @(negedge sys_clk);
        chk("rst tx_bit", tx_bit, 1'b1);
        chk("rst busy", busy, 1'b0);
        chk("rst tx_ready", tx_ready, 1'b0);
        chk("rst bit_strobe", bit_strobe, 1'b0);
        chk("rst done", done, 1'b0);
        chk("rst underrun", underrun, 1'b0);
        sys_rst = 1'b0;

        for (int i = 0; i < 4; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

        // Start coinciding with done is dropped; the next cycle's start is taken
        run_frame(vecs[1], "pre_done");
        start = 1'b1; len = 8'd0;
        @(negedge sys_clk);
        start = 1'b0;
        chk("start on done busy", busy, 1'b0);
        chk("start on done strobe", bit_strobe, 1'b0);
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        chk("start after done busy", busy, 1'b1);
        chk("start after done strobe", bit_strobe, 1'b1);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        chk("abort1 busy", busy, 1'b0);

        // Second start mid-frame is ignored; reset in SYNC abandons cleanly
        @(negedge sys_clk);
        len = 8'd2; start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        pat = 32'd0; strobes = 0; bad_pulse = 0;
        for (int c = 0; c < 70; c++) begin
            if (c > 0) @(negedge sys_clk);
            start = (c == 20);
            if (c == 20) len = 8'd5;
            if (bit_strobe) begin pat = {pat[30:0], tx_bit}; strobes++; end
            if (done || underrun) bad_pulse = 1;
        end
        start = 1'b0;
        chk("midstart strobes", strobes, 18);
        chk("midstart bits", pat, 32'h0002AAAB);
        chk("midstart pulses", bad_pulse, 1'b0);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        chk("sync rst tx_bit", tx_bit, 1'b1);
        chk("sync rst busy", busy, 1'b0);
        chk("sync rst done", done, 1'b0);
        chk("sync rst underrun", underrun, 1'b0);
        sys_rst = 1'b0;
        run_frame(vecs[0], "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fsk_frame_tx.md
FSK_FRAME_TX -- requirements
Module: fsk_frame_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 5000: sys_clk cycles per bit period (legal range 2..65535).
REQ-002 SHALL have parameter PREAMBLE_BYTES, default 2: number of 0xAA preamble bytes (legal range 1..15).
REQ-003 SHALL have parameter SYNC_WORD, default 8'hD3: sync byte sent after the preamble.
REQ-004 SHALL have port sys_clk  in  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port sys_rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port start  in  1  one-cycle frame request; sampled only in IDLE.
REQ-007 SHALL have port len  in  8  payload byte count; captured on an accepted start.
REQ-008 SHALL have port tx_data  in  8  payload byte.
REQ-009 SHALL have port tx_valid  in  1  tx_data valid.
REQ-010 SHALL have port tx_ready  out  1  byte is taken on a cycle where tx_valid and tx_ready are both high.
REQ-011 SHALL have port tx_bit  out  1  serial NRZ bit to the modulator data input; idles at 1.
REQ-012 SHALL have port bit_strobe  out  1  one-cycle pulse on the first cycle of every transmitted bit period.
REQ-013 SHALL have port busy  out  1  high from the cycle after an accepted start until the frame ends.
REQ-014 SHALL have port done  out  1  one-cycle pulse after the last bit period of a good frame.
REQ-015 SHALL have port underrun  out  1  one-cycle pulse when a frame is aborted because no byte was available.

Function
REQ-016 SHALL implement the state machine IDLE -> PREAMBLE -> SYNC -> LEN -> PAYLOAD -> (CRC) -> IDLE.
- PAYLOAD is skipped when len==0.
REQ-017 SHALL send every byte MSB first.
- One bit period is exactly CLK_DIV cycles, timed by a bit counter that wraps from CLK_DIV-1 to 0.
REQ-018 SHALL start the frame, on start=1 in IDLE at cycle t, with the first preamble bit on tx_bit at t+1 together with bit_strobe.
REQ-019 SHALL ignore start while busy=1 (no queuing).
REQ-020 SHALL transmit, in order:
- PREAMBLE_BYTES x 0xAA;
- SYNC_WORD;
- len;
- len payload bytes.
REQ-021 SHALL prefetch payload bytes through a one-byte holding register.
- tx_ready = 1 while in LEN or PAYLOAD, the holding register is empty, and payload bytes remain to fetch.
REQ-022 SHALL, at each payload byte boundary, move the holding register into the shifter.
- If the holding register is empty: pulse underrun, set tx_bit to 1, enter IDLE; done is not pulsed.
REQ-023 SHALL never assert tx_ready when len==0 or after the final payload byte has been fetched.
REQ-024 SHALL, at the end of the last bit period, set tx_bit to 1, clear busy, and pulse done in the same cycle.
- A start on that same cycle is ignored.
- A start on the next cycle is accepted.
REQ-025 SHALL keep tx_bit glitch-free: it changes only on bit_strobe cycles or on abort/frame end.

Reset
REQ-026 SHALL, while sys_rst=1, force:
- state IDLE;
- tx_bit=1;
- tx_ready, bit_strobe, busy, done and underrun all 0;
- bit counter, byte counter and holding register cleared.
REQ-027 SHALL abandon a frame immediately on a reset mid-frame, with no done or underrun pulse.

Configuration
REQ-028 SHALL, with macro FSK_FRAME_CRC_EN defined, append one CRC-8 byte after the payload (CRC state entered after the last payload byte, or after LEN when len==0).
- Polynomial 0x07, init 0x00, no reflection, no final XOR.
- Computed over the len byte and the payload bytes.
REQ-029 SHALL, without FSK_FRAME_CRC_EN, contain no CRC logic and go from the last payload byte (or LEN) directly to frame end.

Structure
REQ-030 SHALL place the following in shared package fsk_pkg:
- the state enumeration typedef;
- constants PREAMBLE_BYTE=8'hAA and CRC8_POLY=8'h07.
REQ-031 SHALL use one sub-module, fsk_crc8: a byte-wide combinational CRC-8 update plus its register, instantiated only under FSK_FRAME_CRC_EN.

Verification (CLK_DIV=4, PREAMBLE_BYTES=2, SYNC_WORD=8'hD3)
REQ-032 SHALL check: len=2, bytes 0x12, 0x34 always valid, no CRC ->
- tx_bit sequence AA AA D3 02 12 34;
- 48 bit periods (192 cycles), then a done pulse.
REQ-033 SHALL check: same frame with FSK_FRAME_CRC_EN -> CRC-8 over 02 12 34, as computed by the bench model (poly 0x07), sent as a seventh byte; done after 224 cycles.
REQ-034 SHALL check: len=0, no CRC ->
- tx_bit sequence AA AA D3 00;
- tx_ready never high;
- done after 128 cycles.
REQ-035 SHALL check: len=3, tx_valid withheld for the second byte -> underrun pulse at that byte boundary, tx_bit=1, busy=0, no done.
REQ-036 SHALL check: start pulsed again mid-frame, then sys_rst asserted during SYNC ->
- the second start has no effect;
- after reset: tx_bit=1, busy=0;
- the next start produces a clean frame.
